// File: rtl/snake_pkg.sv
// Shared snake-game constants: screen geometry, colours and the food-spawn FSM encoding.
package snake_pkg;
  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int LEN_W = 7;
  localparam int X_MAX = 159;
  localparam int Y_MAX = 119;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_FOOD  = 3'b100;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_GEN   = 3'd1;
  localparam logic [2:0] ST_CAPT  = 3'd2;
  localparam logic [2:0] ST_SCAN  = 3'd3;
  localparam logic [2:0] ST_RETRY = 3'd4;
  localparam logic [2:0] ST_PLOT  = 3'd5;
endpackage

// File: rtl/food_body_scan.sv
// Walks the snake body RAM from segment 0 and compares each returned segment with the candidate.
module food_body_scan #(
  parameter int X_W   = snake_pkg::X_W,
  parameter int Y_W   = snake_pkg::Y_W,
  parameter int LEN_W = snake_pkg::LEN_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic [LEN_W-1:0] len,
  input  logic [X_W-1:0]   cand_x,
  input  logic [Y_W-1:0]   cand_y,
  output logic [LEN_W-1:0] seg_addr,
  input  logic [X_W-1:0]   seg_x,
  input  logic [Y_W-1:0]   seg_y,
  output logic             hit,
  output logic             done
);
  import snake_pkg::*;

  localparam logic [LEN_W-1:0] ADDR_ONE = LEN_W'(1);

  logic [LEN_W-1:0] addr_q, addr_d;
  logic             issue_q, issue_d;
  logic             cmp_vld_q, cmp_vld_d;
  logic             cmp_last_q, cmp_last_d;
  logic             at_last;

  // RAM data lags the address by one cycle, so the compare flags trail the issue flag.
  always_comb begin
    at_last    = (addr_q == (len - ADDR_ONE));
    addr_d     = addr_q;
    issue_d    = issue_q;
    cmp_vld_d  = issue_q;
    cmp_last_d = issue_q & at_last;
    if (issue_q) begin
      addr_d = addr_q + ADDR_ONE;
      if (at_last) issue_d = 1'b0;
    end
    if (start) begin
      addr_d     = '0;
      issue_d    = 1'b1;
      cmp_vld_d  = 1'b0;
      cmp_last_d = 1'b0;
    end
    if (clear) begin
      issue_d    = 1'b0;
      cmp_vld_d  = 1'b0;
      cmp_last_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q     <= '0;
      issue_q    <= 1'b0;
      cmp_vld_q  <= 1'b0;
      cmp_last_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      issue_q    <= issue_d;
      cmp_vld_q  <= cmp_vld_d;
      cmp_last_q <= cmp_last_d;
    end
  end

  assign seg_addr = addr_q;
  assign hit      = cmp_vld_q & (seg_x == cand_x) & (seg_y == cand_y);
  assign done     = cmp_last_q & ~hit;
endmodule

// File: rtl/food_spawn_ctrl.sv
// Places food by rejection sampling random coordinates against screen bounds and the snake body.
module food_spawn_ctrl #(
  parameter int         X_W       = snake_pkg::X_W,
  parameter int         Y_W       = snake_pkg::Y_W,
  parameter int         LEN_W     = snake_pkg::LEN_W,
  parameter int         X_MAX     = snake_pkg::X_MAX,
  parameter int         Y_MAX     = snake_pkg::Y_MAX,
  parameter int         MAX_TRIES = 15,
  parameter logic [2:0] FOOD_COL  = snake_pkg::COL_FOOD
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             spawn_req,
  input  logic [X_W-1:0]   head_x,
  input  logic [Y_W-1:0]   head_y,
  output logic             rnd_en,
  input  logic [X_W-1:0]   rnd_x,
  input  logic [Y_W-1:0]   rnd_y,
  input  logic [LEN_W-1:0] snake_len,
  output logic [LEN_W-1:0] seg_addr,
  input  logic [X_W-1:0]   seg_x,
  input  logic [Y_W-1:0]   seg_y,
  output logic             plot_req,
  input  logic             plot_gnt,
  output logic [X_W-1:0]   plot_x,
  output logic [Y_W-1:0]   plot_y,
  output logic [2:0]       plot_colour,
  output logic [X_W-1:0]   food_x,
  output logic [Y_W-1:0]   food_y,
  output logic             food_valid,
  output logic             food_hit,
  output logic             busy,
  output logic             spawn_fail
);
  import snake_pkg::*;

  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);
  localparam logic [TRY_W-1:0] TRY_ONE  = TRY_W'(1);
  localparam logic [X_W-1:0]   X_LIM    = X_W'(X_MAX);
  localparam logic [Y_W-1:0]   Y_LIM    = Y_W'(Y_MAX);

  logic [2:0]       state_q, state_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [X_W-1:0]   cand_x_q, cand_x_d, food_x_q, food_x_d;
  logic [Y_W-1:0]   cand_y_q, cand_y_d, food_y_q, food_y_d;
  logic             food_valid_q, food_valid_d;
  logic             food_hit_q, food_hit_d;
  logic             scan_start, scan_clear, scan_hit, scan_done;
  logic             fail_now;

  food_body_scan #(.X_W(X_W), .Y_W(Y_W), .LEN_W(LEN_W)) u_scan (
    .clock    (clock),
    .reset    (reset),
    .start    (scan_start),
    .clear    (scan_clear),
    .len      (snake_len),
    .cand_x   (cand_x_q),
    .cand_y   (cand_y_q),
    .seg_addr (seg_addr),
    .seg_x    (seg_x),
    .seg_y    (seg_y),
    .hit      (scan_hit),
    .done     (scan_done)
  );

  always_comb begin
    state_d      = state_q;
    tries_d      = tries_q;
    cand_x_d     = cand_x_q;
    cand_y_d     = cand_y_q;
    food_x_d     = food_x_q;
    food_y_d     = food_y_q;
    food_valid_d = food_valid_q;
    scan_start   = 1'b0;
    scan_clear   = 1'b0;
    fail_now     = 1'b0;
    case (state_q)
      ST_IDLE: if (spawn_req) begin
        state_d      = ST_GEN;
        tries_d      = '0;
        food_valid_d = 1'b0;
      end
      ST_GEN: state_d = ST_CAPT;
      ST_CAPT: begin
        cand_x_d = rnd_x;
        cand_y_d = rnd_y;
        if ((rnd_x > X_LIM) || (rnd_y > Y_LIM)) begin
          state_d = ST_RETRY;
        end else if (snake_len == '0) begin
          state_d = ST_PLOT;
        end else begin
          scan_start = 1'b1;
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (scan_hit) begin
          scan_clear = 1'b1;
          state_d    = ST_RETRY;
        end else if (scan_done) begin
          state_d = ST_PLOT;
        end
      end
      ST_RETRY: begin
        if (tries_q == TRY_LAST) begin
          fail_now = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          tries_d = tries_q + TRY_ONE;
          state_d = ST_GEN;
        end
      end
      ST_PLOT: if (plot_gnt) begin
        food_x_d     = cand_x_q;
        food_y_d     = cand_y_q;
        food_valid_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Evaluated on next-state food so food_hit can never be high while food_valid is low.
    food_hit_d = food_valid_d & (head_x == food_x_d) & (head_y == food_y_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      tries_q      <= '0;
      cand_x_q     <= '0;
      cand_y_q     <= '0;
      food_x_q     <= '0;
      food_y_q     <= '0;
      food_valid_q <= 1'b0;
      food_hit_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tries_q      <= tries_d;
      cand_x_q     <= cand_x_d;
      cand_y_q     <= cand_y_d;
      food_x_q     <= food_x_d;
      food_y_q     <= food_y_d;
      food_valid_q <= food_valid_d;
      food_hit_q   <= food_hit_d;
    end
  end

  assign rnd_en      = (state_q == ST_GEN);
  assign plot_req    = (state_q == ST_PLOT);
  assign busy        = (state_q != ST_IDLE);
  assign spawn_fail  = fail_now;
  assign plot_x      = cand_x_q;
  assign plot_y      = cand_y_q;
  assign plot_colour = plot_req ? FOOD_COL : COL_BLACK;
  assign food_x      = food_x_q;
  assign food_y      = food_y_q;
  assign food_valid  = food_valid_q;
  assign food_hit    = food_hit_q;
endmodule

// File: tb/tb_food_spawn_ctrl.sv
// Bench for food_spawn_ctrl: timeline model of each spawn attempt plus directed scenarios.
module tb_food_spawn_ctrl;
  import snake_pkg::*;

  localparam int MAXT = 15;

  logic       clock = 1'b0;
  logic       reset, spawn_req, plot_gnt, rnd_en, plot_req, food_valid, food_hit, busy, spawn_fail;
  logic [7:0] head_x, rnd_x, seg_x, plot_x, food_x;
  logic [6:0] head_y, rnd_y, seg_y, plot_y, food_y;
  logic [6:0] snake_len, seg_addr;
  logic [2:0] plot_colour;

  always #5 clock = ~clock;

  food_spawn_ctrl dut (
    .clock(clock), .reset(reset), .spawn_req(spawn_req), .head_x(head_x), .head_y(head_y),
    .rnd_en(rnd_en), .rnd_x(rnd_x), .rnd_y(rnd_y), .snake_len(snake_len), .seg_addr(seg_addr),
    .seg_x(seg_x), .seg_y(seg_y), .plot_req(plot_req), .plot_gnt(plot_gnt), .plot_x(plot_x),
    .plot_y(plot_y), .plot_colour(plot_colour), .food_x(food_x), .food_y(food_y),
    .food_valid(food_valid), .food_hit(food_hit), .busy(busy), .spawn_fail(spawn_fail)
  );

  // Body RAM with one-cycle read latency
  logic [7:0] body_x [128];
  logic [6:0] body_y [128];
  always @(posedge clock) begin
    seg_x <= body_x[seg_addr];
    seg_y <= body_y[seg_addr];
  end

  typedef struct { bit gen; bit capt; bit fail; int cidx; } rec_t;
  rec_t       q[$];
  rec_t       cur;
  int         phase;      // 0 idle, 1 drawing/scanning, 2 waiting for grant
  bit         accept;
  logic [7:0] acc_x, m_fx;
  logic [6:0] acc_y, m_fy;
  bit         m_fv, m_hit;
  logic [7:0] cl_x [MAXT];
  logic [6:0] cl_y [MAXT];

  int checks = 0, errors = 0;
  int cyc = 0, c0 = 0, strobes = 0, fails_seen = 0, first_plot = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expand one spawn into its per-cycle timeline: every candidate costs GEN+CAPT, then
  // either an immediate retry (off-screen), a scan up to the first colliding segment, or acceptance.
  task automatic build(input int len);
    rec_t r;
    int   j;
    q.delete();
    accept = 0;
    for (int i = 0; i < MAXT; i++) begin
      r = '{1'b1, 1'b0, 1'b0, i}; q.push_back(r);
      r = '{1'b0, 1'b1, 1'b0, i}; q.push_back(r);
      if (cl_x[i] > 8'd159 || cl_y[i] > 7'd119) begin
        r = '{1'b0, 1'b0, (i == MAXT-1), i}; q.push_back(r);
      end else if (len == 0) begin
        accept = 1; acc_x = cl_x[i]; acc_y = cl_y[i];
        break;
      end else begin
        j = -1;
        for (int k = 0; k < len; k++)
          if (j < 0 && body_x[k] == cl_x[i] && body_y[k] == cl_y[i]) j = k;
        if (j >= 0) begin
          for (int k = 0; k < j + 2; k++) begin r = '{1'b0, 1'b0, 1'b0, i}; q.push_back(r); end
          r = '{1'b0, 1'b0, (i == MAXT-1), i}; q.push_back(r);
        end else begin
          for (int k = 0; k < len + 1; k++) begin r = '{1'b0, 1'b0, 1'b0, i}; q.push_back(r); end
          accept = 1; acc_x = cl_x[i]; acc_y = cl_y[i];
          break;
        end
      end
    end
  endtask

  task automatic tick();
    bit         s_rst, s_spawn, s_gnt;
    logic [7:0] s_hx;
    logic [6:0] s_hy;
    s_rst = reset; s_spawn = spawn_req; s_gnt = plot_gnt; s_hx = head_x; s_hy = head_y;
    @(posedge clock);
    #1;
    cyc++;
    if (rnd_en) strobes++;
    if (spawn_fail) fails_seen++;
    if (plot_req && first_plot < 0) first_plot = cyc;
    if (s_rst) begin
      phase = 0; m_fv = 0; m_fx = 0; m_fy = 0; q.delete();
    end else begin
      case (phase)
        0: if (s_spawn) begin
          build(int'(snake_len));
          m_fv = 0; cur = q.pop_front(); phase = 1;
        end
        1: if (q.size() == 0) phase = accept ? 2 : 0;
           else cur = q.pop_front();
        default: if (s_gnt) begin
          m_fx = acc_x; m_fy = acc_y; m_fv = 1; phase = 0;
        end
      endcase
    end
    m_hit = !s_rst && m_fv && (s_hx == m_fx) && (s_hy == m_fy);
    chk("busy",       32'(busy),       32'(phase != 0));
    chk("rnd_en",     32'(rnd_en),     32'(phase == 1 && cur.gen));
    chk("spawn_fail", 32'(spawn_fail), 32'(phase == 1 && cur.fail));
    chk("plot_req",   32'(plot_req),   32'(phase == 2));
    chk("plot_colour", 32'(plot_colour), (phase == 2) ? 32'd4 : 32'd0);
    if (phase == 2) begin
      chk("plot_x", 32'(plot_x), 32'(acc_x));
      chk("plot_y", 32'(plot_y), 32'(acc_y));
    end
    chk("food_valid", 32'(food_valid), 32'(m_fv));
    chk("food_x",     32'(food_x),     32'(m_fx));
    chk("food_y",     32'(food_y),     32'(m_fy));
    chk("food_hit",   32'(food_hit),   32'(m_hit));
    // The generator only has to be right during the capture cycle; elsewhere it is noise.
    if (phase == 1 && cur.capt) begin
      rnd_x = cl_x[cur.cidx]; rnd_y = cl_y[cur.cidx];
    end else begin
      rnd_x = 8'($urandom); rnd_y = 7'($urandom);
    end
  endtask

  task automatic fill_list(input logic [7:0] x0, input logic [6:0] y0,
                           input logic [7:0] x1, input logic [6:0] y1);
    cl_x[0] = x0; cl_y[0] = y0;
    for (int i = 1; i < MAXT; i++) begin cl_x[i] = x1; cl_y[i] = y1; end
  endtask

  task automatic set_std_body();
    snake_len = 7'd3;
    body_x[0] = 8'd10; body_y[0] = 7'd10;
    body_x[1] = 8'd11; body_y[1] = 7'd10;
    body_x[2] = 8'd12; body_y[2] = 7'd10;
  endtask

  task automatic spawn_pulse();
    strobes = 0; fails_seen = 0; first_plot = -1; c0 = cyc;
    spawn_req = 1'b1; tick(); spawn_req = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin tick(); n++; end
    chk("wait_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin body_x[i] = 8'd0; body_y[i] = 7'd0; end
    fill_list(8'd0, 7'd0, 8'd0, 7'd0);
    phase = 0; m_fv = 0; m_fx = 0; m_fy = 0; m_hit = 0; cur = '{1'b0, 1'b0, 1'b0, 0};
    reset = 1'b1; spawn_req = 1'b0; plot_gnt = 1'b0; head_x = 8'd0; head_y = 7'd0;
    snake_len = 7'd0; rnd_x = 8'd0; rnd_y = 7'd0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_seg_addr", 32'(seg_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();

    // Clean spawn, L=3, grant always available
    set_std_body(); plot_gnt = 1'b1; head_x = 8'd0; head_y = 7'd0;
    fill_list(8'd50, 7'd60, 8'd50, 7'd60);
    spawn_pulse(); wait_idle(50); tick();
    chk("clean_plot_cycle", 32'(first_plot - c0), 32'd7);
    chk("clean_food_x", 32'(food_x), 32'd50);
    chk("clean_food_y", 32'(food_y), 32'd60);
    chk("clean_food_valid", 32'(food_valid), 32'd1);

    // Body collision at segment 1, then a free square
    fill_list(8'd11, 7'd10, 8'd20, 7'd20);
    spawn_pulse(); wait_idle(80); tick();
    chk("coll_strobes", 32'(strobes), 32'd2);
    chk("coll_plot_cycle", 32'(first_plot - c0), 32'd13);
    chk("coll_food_x", 32'(food_x), 32'd20);
    chk("coll_food_y", 32'(food_y), 32'd20);

    // Off-screen candidate rejected without scanning
    fill_list(8'd160, 7'd5, 8'd159, 7'd119);
    spawn_pulse(); wait_idle(80); tick();
    chk("offs_plot_cycle", 32'(first_plot - c0), 32'd10);
    chk("offs_food_x", 32'(food_x), 32'd159);
    chk("offs_food_y", 32'(food_y), 32'd119);

    // Every candidate lands on the head
    fill_list(8'd10, 7'd10, 8'd10, 7'd10);
    spawn_pulse(); wait_idle(200); tick();
    chk("exh_strobes", 32'(strobes), 32'd15);
    chk("exh_fail_pulses", 32'(fails_seen), 32'd1);
    chk("exh_food_valid", 32'(food_valid), 32'd0);
    chk("exh_plot_seen", 32'(first_plot), 32'hffffffff);

    // Grant stall with an ignored spawn pulse, then head lands on the food
    plot_gnt = 1'b0;
    fill_list(8'd50, 7'd60, 8'd50, 7'd60);
    spawn_pulse();
    for (int i = 0; i < 26; i++) begin
      spawn_req = (i == 15);
      tick();
    end
    spawn_req = 1'b0;
    chk("stall_plot_req", 32'(plot_req), 32'd1);
    chk("stall_strobes", 32'(strobes), 32'd1);
    head_x = 8'd50; head_y = 7'd60; plot_gnt = 1'b1;
    tick(); plot_gnt = 1'b0; tick();
    chk("hit_food_valid", 32'(food_valid), 32'd1);
    chk("hit_food_hit", 32'(food_hit), 32'd1);
    head_x = 8'd0; tick(); tick();
    chk("hit_cleared", 32'(food_hit), 32'd0);

    // Reset while scanning
    plot_gnt = 1'b1;
    spawn_pulse(); tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_scan_busy", 32'(busy), 32'd0);
    chk("rst_scan_plot_req", 32'(plot_req), 32'd0);
    chk("rst_scan_food_valid", 32'(food_valid), 32'd0);
    tick();

    // Randomized traffic
    for (int it = 0; it < 4000; it++) begin
      automatic int r = int'($urandom_range(0, 15));
      spawn_req = 1'b0;
      plot_gnt  = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) begin head_x = m_fx; head_y = m_fy; end
      else begin head_x = 8'($urandom_range(0, 15)); head_y = 7'($urandom_range(0, 15)); end
      if (phase == 0 && r < 4) begin
        for (int i = 0; i < MAXT; i++) begin
          automatic int sel = int'($urandom_range(0, 3));
          if (sel == 0) begin
            cl_x[i] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(160, 255)) : 8'($urandom_range(0, 159));
            cl_y[i] = (cl_x[i] > 8'd159) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(120, 127));
          end else if (sel == 1 && snake_len != 0) begin
            automatic int k = int'($urandom_range(0, int'(snake_len) - 1));
            cl_x[i] = body_x[k]; cl_y[i] = body_y[k];
          end else begin
            cl_x[i] = 8'($urandom_range(0, 7)); cl_y[i] = 7'($urandom_range(0, 7));
          end
        end
        spawn_req = 1'b1;
      end else if (phase == 0 && r == 4) begin
        snake_len = 7'($urandom_range(0, 6));
        for (int k = 0; k < 7; k++) begin
          body_x[k] = 8'($urandom_range(0, 7)); body_y[k] = 7'($urandom_range(0, 7));
        end
      end else if (phase != 0 && r == 5) begin
        spawn_req = 1'b1;
      end
      tick();
    end
    spawn_req = 1'b0;
    plot_gnt  = 1'b1;
    wait_idle(300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
